// File: rtl/tdc_sweep_controller.sv
// rtl/tdc_sweep_controller.sv - t_stop_coarse sweep sequencer for the TDC with run watchdog
module tdc_sweep_controller #(
  parameter int TIMEOUT_CYCLES = 16383
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic        abort,
  input  logic [7:0]  cfg_t_start,
  input  logic [7:0]  cfg_stop_first,
  input  logic [7:0]  cfg_stop_last,
  input  logic [7:0]  cfg_stop_step,
  input  logic [15:0] cfg_runs_per_point,
  input  logic        ready_flag,
  output logic        run_sequencer,
  output logic [7:0]  t_start_coarse,
  output logic [7:0]  t_stop_coarse,
  output logic        busy,
  output logic        done,
  output logic        timeout_error,
  output logic [7:0]  point_index,
  output logic [15:0] run_count
);
  localparam int WD_W = $clog2(TIMEOUT_CYCLES + 1);

  typedef enum logic [2:0] {IDLE, ARM, WAIT_BUSY, WAIT_READY, NEXT, DONE} state_t;

  state_t          state_q, state_d;
  logic [WD_W-1:0] wdog_q;
  logic [7:0]      stop_last_q, stop_step_q;
  logic [15:0]     runs_q;
  logic [15:0]     run_inc;
  logic [8:0]      stop_sum;
  logic            waiting, wd_expired, point_done, sweep_end;
  logic            accept, timeout_hit;

  assign waiting    = (state_q == ARM) || (state_q == WAIT_BUSY) || (state_q == WAIT_READY);
  assign wd_expired = waiting && (wdog_q == WD_W'(TIMEOUT_CYCLES - 1));
  assign run_inc    = run_count + 16'd1;
  // 9-bit sum so a wrap past 255 ends the sweep instead of restarting low
  assign stop_sum   = {1'b0, t_stop_coarse} + {1'b0, stop_step_q};
  assign point_done = (run_inc >= runs_q);
  assign sweep_end  = (stop_step_q == 8'd0) || (stop_sum > {1'b0, stop_last_q}) || stop_sum[8];
  assign busy       = (state_q != IDLE);

  always_comb begin
    state_d       = state_q;
    run_sequencer = 1'b0;
    done          = 1'b0;
    accept        = 1'b0;
    timeout_hit   = 1'b0;
    case (state_q)
      IDLE: begin
        if (start && !abort) begin
          accept  = 1'b1;
          state_d = ARM;
        end
      end
      ARM: begin
        if (abort) state_d = IDLE;
        else if (wd_expired) begin
          timeout_hit = 1'b1;
          state_d     = IDLE;
        end else if (ready_flag) begin
          run_sequencer = 1'b1;
          state_d       = WAIT_BUSY;
        end
      end
      WAIT_BUSY: begin
        if (abort) state_d = IDLE;
        else if (wd_expired) begin
          timeout_hit = 1'b1;
          state_d     = IDLE;
        end else if (!ready_flag) state_d = WAIT_READY;
      end
      WAIT_READY: begin
        if (abort) state_d = IDLE;
        else if (wd_expired) begin
          timeout_hit = 1'b1;
          state_d     = IDLE;
        end else if (ready_flag) state_d = NEXT;
      end
      NEXT: begin
        if (abort) state_d = IDLE;
        else if (!point_done || !sweep_end) state_d = ARM;
        else state_d = DONE;
      end
      DONE: begin
        done    = !abort;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q        <= IDLE;
      wdog_q         <= '0;
      stop_last_q    <= 8'd0;
      stop_step_q    <= 8'd0;
      runs_q         <= 16'd0;
      t_start_coarse <= 8'd0;
      t_stop_coarse  <= 8'd0;
      point_index    <= 8'd0;
      run_count      <= 16'd0;
      timeout_error  <= 1'b0;
    end else begin
      state_q <= state_d;
      if (state_d != state_q) wdog_q <= '0;
      else if (waiting) wdog_q <= wdog_q + WD_W'(1);

      if (accept) begin
        stop_last_q    <= cfg_stop_last;
        stop_step_q    <= cfg_stop_step;
        runs_q         <= (cfg_runs_per_point == 16'd0) ? 16'd1 : cfg_runs_per_point;
        t_start_coarse <= cfg_t_start;
        t_stop_coarse  <= cfg_stop_first;
        point_index    <= 8'd0;
        run_count      <= 16'd0;
        timeout_error  <= 1'b0;
      end
      if (timeout_hit) timeout_error <= 1'b1;

      if (state_q == NEXT && !abort) begin
        run_count <= run_inc;
        if (point_done && !sweep_end) begin
          t_stop_coarse <= stop_sum[7:0];
          run_count     <= 16'd0;
          point_index   <= point_index + 8'd1;
        end
      end
    end
  end
endmodule

// File: tb/tb_tdc_sweep_controller.sv
// tb/tb_tdc_sweep_controller.sv - directed bench for tdc_sweep_controller
module tb_tdc_sweep_controller;
  logic        clk = 1'b0;
  logic        reset, start, abort, ready_flag;
  logic [7:0]  cfg_t_start, cfg_stop_first, cfg_stop_last, cfg_stop_step;
  logic [15:0] cfg_runs_per_point;
  logic        run_sequencer, busy, done, timeout_error;
  logic [7:0]  t_start_coarse, t_stop_coarse, point_index;
  logic [15:0] run_count;

  int errors = 0;
  int checks = 0;
  int p0, d0;
  logic hold_ready;

  always #5 clk = ~clk;

  tdc_sweep_controller #(.TIMEOUT_CYCLES(100)) dut (
    .clk(clk), .reset(reset), .start(start), .abort(abort),
    .cfg_t_start(cfg_t_start), .cfg_stop_first(cfg_stop_first),
    .cfg_stop_last(cfg_stop_last), .cfg_stop_step(cfg_stop_step),
    .cfg_runs_per_point(cfg_runs_per_point), .ready_flag(ready_flag),
    .run_sequencer(run_sequencer), .t_start_coarse(t_start_coarse),
    .t_stop_coarse(t_stop_coarse), .busy(busy), .done(done),
    .timeout_error(timeout_error), .point_index(point_index), .run_count(run_count)
  );

  // Sequencer model: goes busy for 50 cycles after each accepted run pulse
  int busy_cnt;
  always @(posedge clk) begin
    if (!reset) begin
      ready_flag <= 1'b1;
      busy_cnt   <= 0;
    end else if (run_sequencer && !hold_ready) begin
      ready_flag <= 1'b0;
      busy_cnt   <= 50;
    end else if (busy_cnt > 0) begin
      busy_cnt <= busy_cnt - 1;
      if (busy_cnt == 1) ready_flag <= 1'b1;
    end
  end

  int         pulse_cnt = 0;
  int         done_cnt = 0;
  int         back2back = 0;
  logic       prev_run = 1'b0;
  logic [7:0] stop_log [64];
  always @(negedge clk) begin
    if (run_sequencer === 1'b1) begin
      if (pulse_cnt < 64) stop_log[pulse_cnt] = t_stop_coarse;
      pulse_cnt++;
      if (prev_run) back2back++;
    end
    prev_run = (run_sequencer === 1'b1);
    if (done === 1'b1) done_cnt++;
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(negedge clk);
      #1;
    end
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic start_sweep(input logic [7:0] first, input logic [7:0] last,
                             input logic [7:0] step, input logic [15:0] runs);
    cfg_stop_first     = first;
    cfg_stop_last      = last;
    cfg_stop_step      = step;
    cfg_runs_per_point = runs;
    p0    = pulse_cnt;
    d0    = done_cnt;
    start = 1'b1;
    tick(1);
    start = 1'b0;
  endtask

  task automatic wait_idle(input string tag);
    int n;
    n = 0;
    while (busy !== 1'b0 && n < 3000) begin
      tick(1);
      n++;
    end
    check({tag, "_idle"}, {31'd0, busy}, 32'd0);
  endtask

  initial begin
    logic [7:0] exp_stop [6];
    exp_stop = '{8'd10, 8'd10, 8'd20, 8'd20, 8'd30, 8'd30};
    hold_ready = 1'b0;
    reset = 1'b0;
    start = 1'b1;
    abort = 1'b0;
    cfg_t_start = 8'd7;
    cfg_stop_first = 8'd10;
    cfg_stop_last = 8'd30;
    cfg_stop_step = 8'd10;
    cfg_runs_per_point = 16'd2;
    tick(3);
    check("rst_outs", {4'd0, run_sequencer, busy, done, timeout_error,
                       t_start_coarse, t_stop_coarse, point_index}, 32'd0);
    check("rst_run_count", {16'd0, run_count}, 32'd0);
    start = 1'b0;
    reset = 1'b1;
    tick(2);

    // Three points of two runs, with cfg and start changes mid-sweep
    start_sweep(8'd10, 8'd30, 8'd10, 16'd2);
    check("t1_busy", {31'd0, busy}, 32'd1);
    check("t1_t_start", {24'd0, t_start_coarse}, 32'd7);
    check("t1_t_stop0", {24'd0, t_stop_coarse}, 32'd10);
    cfg_stop_last = 8'd200;
    cfg_runs_per_point = 16'd5;
    tick(20);
    start = 1'b1;
    tick(5);
    start = 1'b0;
    wait_idle("t1");
    check("t1_pulses", pulse_cnt - p0, 32'd6);
    check("t1_done", done_cnt - d0, 32'd1);
    for (int i = 0; i < 6; i++)
      check($sformatf("t1_stop%0d", i), {24'd0, stop_log[p0 + i]}, {24'd0, exp_stop[i]});
    check("t1_point_index", {24'd0, point_index}, 32'd2);
    check("t1_run_count", {16'd0, run_count}, 32'd2);
    check("t1_t_stop_final", {24'd0, t_stop_coarse}, 32'd30);
    check("t1_timeout", {31'd0, timeout_error}, 32'd0);

    start_sweep(8'd5, 8'd5, 8'd10, 16'd0);
    wait_idle("t2");
    check("t2_pulses", pulse_cnt - p0, 32'd1);
    check("t2_done", done_cnt - d0, 32'd1);
    check("t2_run_count", {16'd0, run_count}, 32'd1);

    start_sweep(8'd250, 8'd255, 8'd10, 16'd1);
    wait_idle("t3");
    check("t3_pulses", pulse_cnt - p0, 32'd1);
    check("t3_t_stop", {24'd0, t_stop_coarse}, 32'd250);
    check("t3_point_index", {24'd0, point_index}, 32'd0);

    start_sweep(8'd40, 8'd20, 8'd5, 16'd1);
    wait_idle("t4");
    check("t4_pulses", pulse_cnt - p0, 32'd1);
    check("t4_t_stop", {24'd0, t_stop_coarse}, 32'd40);

    start_sweep(8'd3, 8'd100, 8'd0, 16'd1);
    wait_idle("t5");
    check("t5_pulses", pulse_cnt - p0, 32'd1);
    check("t5_done", done_cnt - d0, 32'd1);

    // Watchdog: sequencer never drops ready after the run pulse
    hold_ready = 1'b1;
    tick(1);
    start_sweep(8'd1, 8'd1, 8'd1, 16'd1);
    check("to_pulse", {31'd0, run_sequencer}, 32'd1);
    tick(100);
    check("to_busy_before", {30'd0, busy, timeout_error}, 32'd2);
    tick(1);
    check("to_busy_after", {30'd0, busy, timeout_error}, 32'd1);
    check("to_done", done_cnt - d0, 32'd0);
    check("to_pulses", pulse_cnt - p0, 32'd1);
    hold_ready = 1'b0;
    tick(1);
    start_sweep(8'd1, 8'd1, 8'd1, 16'd1);
    check("to_cleared", {31'd0, timeout_error}, 32'd0);
    wait_idle("to_retry");
    check("to_retry_done", done_cnt - d0, 32'd1);

    // Abort while the sequencer is busy
    start_sweep(8'd10, 8'd30, 8'd10, 16'd2);
    tick(10);
    check("ab_busy", {31'd0, busy}, 32'd1);
    abort = 1'b1;
    tick(1);
    check("ab_idle", {31'd0, busy}, 32'd0);
    abort = 1'b0;
    tick(150);
    check("ab_pulses", pulse_cnt - p0, 32'd1);
    check("ab_done", done_cnt - d0, 32'd0);
    check("ab_still_idle", {31'd0, busy}, 32'd0);

    // Reset mid-sweep, then a normal sweep
    start_sweep(8'd10, 8'd30, 8'd10, 16'd2);
    tick(10);
    reset = 1'b0;
    tick(1);
    check("mr_outs", {4'd0, run_sequencer, busy, done, timeout_error,
                      t_start_coarse, t_stop_coarse, point_index}, 32'd0);
    check("mr_run_count", {16'd0, run_count}, 32'd0);
    reset = 1'b1;
    tick(1);
    check("mr_no_done", done_cnt - d0, 32'd0);
    start_sweep(8'd5, 8'd5, 8'd10, 16'd0);
    wait_idle("mr_new");
    check("mr_new_pulses", pulse_cnt - p0, 32'd1);
    check("mr_new_done", done_cnt - d0, 32'd1);

    check("back_to_back", back2back, 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
